// File: rtl/csr_file_m_if.sv
// csr_file_m_if: CSR access, writeback and interrupt bundle for csr_file_m.
// The master side is the pipeline; the slave side is the CSR file.
interface csr_file_m_if;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        csr_rd;
    logic        csr_wr;
    logic [1:0]  csr_op;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] pc;
    logic        is_mret;
    logic        irq_ext;
    logic        irq_timer;
    logic        excep;
    logic [31:0] epc;

    modport master (
        output addr, wdata, csr_rd, csr_wr, csr_op,
        output valid, pc, is_mret, irq_ext, irq_timer,
        input  rdata, excep, epc
    );

    modport slave (
        input  addr, wdata, csr_rd, csr_wr, csr_op,
        input  valid, pc, is_mret, irq_ext, irq_timer,
        output rdata, excep, epc
    );
endinterface

// File: rtl/csr_file_m.sv
// csr_file_m: machine-mode CSR file with interrupt trap and mret sequencing.
// Define CSR_COUNTERS_EN to add 64-bit mcycle/minstret counters.
module csr_file_m #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter bit          VECTORED  = 1'b0
) (
    input logic         i_clk,
    input logic         i_rst,
    csr_file_m_if.slave bus
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
`ifdef CSR_COUNTERS_EN
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
`endif

    logic        r_mie_b;
    logic        r_mpie;
    logic        r_meie;
    logic        r_mtie;
    logic        r_meip;
    logic        r_mtip;
    logic [31:2] r_mtvec_base;
    logic        r_mtvec_mode;
    logic [31:0] r_mscratch;
    logic [31:2] r_mepc;
    logic [31:0] r_mcause;

    logic [31:0] w_mstatus;
    logic [31:0] w_mie;
    logic [31:0] w_mip;
    logic [31:0] w_mtvec;
    logic [31:0] w_old;
    logic [31:0] w_new;
    logic        w_pend_e;
    logic        w_pend_t;
    logic        w_take;
    logic        w_mret;
    logic        w_wen;
    logic [4:0]  w_code;
    logic [31:0] w_base;
    logic [31:0] w_voff;
    logic        w_unused;

    assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie_b, 3'd0};
    assign w_mie     = {20'd0, r_meie, 3'd0, r_mtie, 7'd0};
    assign w_mip     = {20'd0, r_meip, 3'd0, r_mtip, 7'd0};
    assign w_mtvec   = {r_mtvec_base, 1'b0, r_mtvec_mode};

    // External interrupt outranks timer when both are pending.
    assign w_pend_e = r_meie & r_meip;
    assign w_pend_t = r_mtie & r_mtip;
    assign w_take   = bus.valid & r_mie_b & (w_pend_e | w_pend_t);
    assign w_mret   = bus.valid & bus.is_mret & ~w_take;
    assign w_wen    = bus.csr_wr & (bus.csr_op != 2'b11) & ~w_take;
    assign w_code   = w_pend_e ? 5'd11 : 5'd7;

    assign w_base = {r_mtvec_base, 2'b00};
    assign w_voff = r_mtvec_mode ? {25'd0, w_code, 2'b00} : 32'd0;

    assign bus.excep = w_take;
    assign bus.epc   = w_take ? (w_base + w_voff) : {r_mepc, 2'b00};
    assign bus.rdata = bus.csr_rd ? w_old : 32'd0;

    assign w_unused = &{1'b0, bus.pc[1:0]};

`ifdef CSR_COUNTERS_EN
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;
`endif

    always_comb begin
        w_old = 32'd0;
        case (bus.addr)
            A_MSTATUS:   w_old = w_mstatus;
            A_MIE:       w_old = w_mie;
            A_MTVEC:     w_old = w_mtvec;
            A_MSCRATCH:  w_old = r_mscratch;
            A_MEPC:      w_old = {r_mepc, 2'b00};
            A_MCAUSE:    w_old = r_mcause;
            A_MIP:       w_old = w_mip;
`ifdef CSR_COUNTERS_EN
            A_MCYCLE:    w_old = r_mcycle[31:0];
            A_MCYCLEH:   w_old = r_mcycle[63:32];
            A_MINSTRET:  w_old = r_minstret[31:0];
            A_MINSTRETH: w_old = r_minstret[63:32];
`endif
            default:     w_old = 32'd0;
        endcase
    end

    always_comb begin
        w_new = bus.wdata;
        case (bus.csr_op)
            2'b01:   w_new = w_old | bus.wdata;
            2'b10:   w_new = w_old & ~bus.wdata;
            default: w_new = bus.wdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mie_b      <= 1'b0;
            r_mpie       <= 1'b0;
            r_meie       <= 1'b0;
            r_mtie       <= 1'b0;
            r_meip       <= 1'b0;
            r_mtip       <= 1'b0;
            r_mtvec_base <= MTVEC_RST[31:2];
            r_mtvec_mode <= 1'b0;
            r_mscratch   <= 32'd0;
            r_mepc       <= 30'd0;
            r_mcause     <= 32'd0;
        end else begin
            r_meip <= bus.irq_ext;
            r_mtip <= bus.irq_timer;
            // Trap beats mret beats a software write to mstatus.
            if (w_take) begin
                r_mpie   <= r_mie_b;
                r_mie_b  <= 1'b0;
                r_mepc   <= bus.pc[31:2];
                r_mcause <= {1'b1, 26'd0, w_code};
            end else if (w_mret) begin
                r_mie_b <= r_mpie;
                r_mpie  <= 1'b1;
            end else if (w_wen && bus.addr == A_MSTATUS) begin
                r_mie_b <= w_new[3];
                r_mpie  <= w_new[7];
            end
            if (w_wen) begin
                case (bus.addr)
                    A_MIE: begin
                        r_meie <= w_new[11];
                        r_mtie <= w_new[7];
                    end
                    A_MTVEC: begin
                        r_mtvec_base <= w_new[31:2];
                        r_mtvec_mode <= VECTORED ? w_new[0] : 1'b0;
                    end
                    A_MSCRATCH: r_mscratch <= w_new;
                    A_MEPC:     r_mepc     <= w_new[31:2];
                    A_MCAUSE:   r_mcause   <= w_new;
                    default:    ;
                endcase
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mcycle   <= 64'd0;
            r_minstret <= 64'd0;
        end else begin
            if (w_wen && bus.addr == A_MCYCLE)
                r_mcycle[31:0] <= w_new;
            else if (w_wen && bus.addr == A_MCYCLEH)
                r_mcycle[63:32] <= w_new;
            else
                r_mcycle <= r_mcycle + 64'd1;

            if (w_wen && bus.addr == A_MINSTRET)
                r_minstret[31:0] <= w_new;
            else if (w_wen && bus.addr == A_MINSTRETH)
                r_minstret[63:32] <= w_new;
            else if (bus.valid && !w_take)
                r_minstret <= r_minstret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_csr_file_m.sv
// tb_csr_file_m: directed table, hand sequences and randomized model check
// for csr_file_m in direct (u_dut0) and vectored (u_dut1) builds.
module tb_csr_file_m;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    csr_file_m_if bus0 ();
    csr_file_m_if bus1 ();

    assign bus1.addr      = bus0.addr;
    assign bus1.wdata     = bus0.wdata;
    assign bus1.csr_rd    = bus0.csr_rd;
    assign bus1.csr_wr    = bus0.csr_wr;
    assign bus1.csr_op    = bus0.csr_op;
    assign bus1.valid     = bus0.valid;
    assign bus1.pc        = bus0.pc;
    assign bus1.is_mret   = bus0.is_mret;
    assign bus1.irq_ext   = bus0.irq_ext;
    assign bus1.irq_timer = bus0.irq_timer;

    csr_file_m #(.MTVEC_RST(32'h0), .VECTORED(1'b0)) u_dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus0.slave)
    );

    csr_file_m #(.MTVEC_RST(32'h0), .VECTORED(1'b1)) u_dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [11:0] a;
        logic [31:0] wd;
        logic        rd;
        logic        wr;
        logic [1:0]  op;
        logic        v;
        logic [31:0] pc;
        logic        mr;
        logic        ie;
        logic        it;
        logic [31:0] xr;
        logic        xe;
        logic [31:0] xp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(
        logic r, logic [11:0] a, logic [31:0] wd,
        logic rd, logic wr, logic [1:0] op,
        logic v, logic [31:0] pc, logic mr,
        logic ie, logic it,
        logic [31:0] xr, logic xe, logic [31:0] xp);
        vec_t t;
        t.r = r; t.a = a; t.wd = wd;
        t.rd = rd; t.wr = wr; t.op = op;
        t.v = v; t.pc = pc; t.mr = mr;
        t.ie = ie; t.it = it;
        t.xr = xr; t.xe = xe; t.xp = xp;
        return t;
    endfunction

    task automatic drv(input vec_t t);
        rst            = t.r;
        bus0.addr      = t.a;
        bus0.wdata     = t.wd;
        bus0.csr_rd    = t.rd;
        bus0.csr_wr    = t.wr;
        bus0.csr_op    = t.op;
        bus0.valid     = t.v;
        bus0.pc        = t.pc;
        bus0.is_mret   = t.mr;
        bus0.irq_ext   = t.ie;
        bus0.irq_timer = t.it;
    endtask

    task automatic chk(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    // Reference model: CSR words by slot, masked on write.
    logic [31:0] mreg [2][7];
    logic [31:0] mmip [2];
    logic [63:0] mcyc [2];
    logic [63:0] mins [2];

    function automatic int slot(logic [11:0] a);
        case (a)
            12'h300: return 0;
            12'h304: return 1;
            12'h305: return 2;
            12'h340: return 3;
            12'h341: return 4;
            12'h342: return 5;
            12'h344: return 6;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] wmask(int k, int s);
        case (s)
            0:       return 32'h0000_0088;
            1:       return 32'h0000_0880;
            2:       return (k == 1) ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;
            4:       return 32'hFFFF_FFFC;
            6:       return 32'h0;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] mread(int k, logic [11:0] a);
        int s;
        s = slot(a);
        if (s == 6) return mmip[k];
        if (s == 0) return mreg[k][0] | 32'h1800;
        if (s >= 0) return mreg[k][s];
`ifdef CSR_COUNTERS_EN
        if (a == 12'hB00) return mcyc[k][31:0];
        if (a == 12'hB80) return mcyc[k][63:32];
        if (a == 12'hB02) return mins[k][31:0];
        if (a == 12'hB82) return mins[k][63:32];
`endif
        return 32'h0;
    endfunction

    task automatic mreset(input int k);
        for (int s = 0; s < 7; s++) mreg[k][s] = 32'h0;
        mmip[k] = 32'h0;
        mcyc[k] = 64'h0;
        mins[k] = 64'h0;
    endtask

    task automatic mstep(input int k, input logic [31:0] g_rd,
                         input logic g_ex, input logic [31:0] g_epc);
        logic [31:0] old, nv, pend, base, xepc;
        logic        take, mret, wen;
        int          s, code;
        s    = slot(bus0.addr);
        old  = mread(k, bus0.addr);
        pend = mreg[k][1] & mmip[k];
        take = bus0.valid && mreg[k][0][3] && (pend != 0);
        code = pend[11] ? 11 : 7;
        base = mreg[k][2] & ~32'h3;
        if (take)
            xepc = base + (mreg[k][2][0] ? 32'(code * 4) : 32'h0);
        else
            xepc = mreg[k][4];
        chk($sformatf("rnd%0d rdata", k), g_rd,
            bus0.csr_rd ? old : 32'h0);
        chk($sformatf("rnd%0d excep", k), {31'd0, g_ex}, {31'd0, take});
        chk($sformatf("rnd%0d epc", k), g_epc, xepc);
        case (bus0.csr_op)
            2'b01:   nv = old | bus0.wdata;
            2'b10:   nv = old & ~bus0.wdata;
            default: nv = bus0.wdata;
        endcase
        wen  = bus0.csr_wr && bus0.csr_op != 2'b11 && !take;
        mret = bus0.valid && bus0.is_mret && !take;
        if (rst) begin
            mreset(k);
        end else begin
            if (wen && s >= 0 && s <= 5 && !(mret && s == 0))
                mreg[k][s] = nv & wmask(k, s);
            if (take) begin
                mreg[k][4] = bus0.pc & ~32'h3;
                mreg[k][5] = 32'h8000_0000 | code;
                mreg[k][0] = mreg[k][0][3] ? 32'h80 : 32'h0;
            end else if (mret) begin
                mreg[k][0] = mreg[k][0][7] ? 32'h88 : 32'h80;
            end
`ifdef CSR_COUNTERS_EN
            if (wen && bus0.addr == 12'hB00) mcyc[k][31:0] = nv;
            else if (wen && bus0.addr == 12'hB80) mcyc[k][63:32] = nv;
            else mcyc[k] = mcyc[k] + 64'd1;
            if (wen && bus0.addr == 12'hB02) mins[k][31:0] = nv;
            else if (wen && bus0.addr == 12'hB82) mins[k][63:32] = nv;
            else if (bus0.valid && !take) mins[k] = mins[k] + 64'd1;
`endif
            mmip[k] = (bus0.irq_ext ? 32'h800 : 32'h0)
                    | (bus0.irq_timer ? 32'h80 : 32'h0);
        end
    endtask

    logic [11:0] alist [14] = '{
        12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
        12'h7C0, 12'h000, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h301
    };

    initial begin
        vec_t z;
        logic ie_r, it_r;
        total = 0;
        bad   = 0;
        z = mkv(1, 12'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(z);
        repeat (2) @(negedge clk);

        //           r  addr     wdata        rd wr op v  pc     mr ie it   rdata        ex epc
        tbl.push_back(mkv(1, 12'h300, 32'h0,        0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mkv(0, 12'h300, 32'h0,        1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h1800,     0, 32'h0));
        tbl.push_back(mkv(0, 12'h305, 32'h8000_0103, 1, 1, 0, 0, 32'h0,  0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mkv(0, 12'h305, 32'h0,        1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h8000_0100, 0, 32'h0));
        tbl.push_back(mkv(0, 12'h340, 32'hF0,       0, 1, 0, 0, 32'h0,   0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mkv(0, 12'h340, 32'h0F,       1, 1, 1, 0, 32'h0,   0, 0, 0, 32'hF0,       0, 32'h0));
        tbl.push_back(mkv(0, 12'h340, 32'h0,        1, 0, 0, 0, 32'h0,   0, 0, 0, 32'hFF,       0, 32'h0));
        tbl.push_back(mkv(0, 12'h340, 32'h0F,       1, 1, 2, 0, 32'h0,   0, 0, 0, 32'hFF,       0, 32'h0));
        tbl.push_back(mkv(0, 12'h340, 32'h0,        1, 0, 0, 0, 32'h0,   0, 0, 0, 32'hF0,       0, 32'h0));
        tbl.push_back(mkv(0, 12'h341, 32'h8000_0103, 0, 1, 0, 0, 32'h0,  0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mkv(0, 12'h341, 32'h0,        1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h8000_0100, 0, 32'h8000_0100));
        tbl.push_back(mkv(0, 12'h341, 32'h8000_0100, 1, 1, 2, 0, 32'h0,  0, 0, 0, 32'h8000_0100, 0, 32'h8000_0100));
        tbl.push_back(mkv(0, 12'h341, 32'h0,        0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mkv(0, 12'h340, 32'h0,        1, 1, 3, 0, 32'h0,   0, 0, 0, 32'hF0,       0, 32'h0));
        tbl.push_back(mkv(0, 12'h340, 32'h0,        1, 0, 0, 0, 32'h0,   0, 0, 0, 32'hF0,       0, 32'h0));
        tbl.push_back(mkv(0, 12'h7C0, 32'hFFFF_FFFF, 1, 1, 0, 0, 32'h0,  0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mkv(0, 12'h7C0, 32'h0,        1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mkv(0, 12'h344, 32'hFFFF_FFFF, 1, 1, 0, 0, 32'h0,  0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mkv(0, 12'h344, 32'h0,        1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,        0, 32'h0));
        tbl.push_back(mkv(0, 12'h300, 32'hFFFF_FFFF, 1, 1, 0, 0, 32'h0,  0, 0, 0, 32'h1800,     0, 32'h0));
        tbl.push_back(mkv(0, 12'h300, 32'h0,        1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h1888,     0, 32'h0));
        tbl.push_back(mkv(0, 12'h304, 32'h80,       1, 1, 0, 0, 32'h0,   0, 0, 1, 32'h0,        0, 32'h0));
        tbl.push_back(mkv(0, 12'h344, 32'h0,        1, 0, 0, 0, 32'h0,   0, 0, 1, 32'h80,       0, 32'h0));
        tbl.push_back(mkv(0, 12'h340, 32'hDEAD_0000, 1, 1, 0, 1, 32'h100, 0, 0, 1, 32'hF0,      1, 32'h8000_0100));
        tbl.push_back(mkv(0, 12'h341, 32'h0,        1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h100,      0, 32'h100));
        tbl.push_back(mkv(0, 12'h342, 32'h0,        1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h8000_0007, 0, 32'h100));
        tbl.push_back(mkv(0, 12'h300, 32'h0,        1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h1880,     0, 32'h100));
        tbl.push_back(mkv(0, 12'h340, 32'h0,        1, 0, 0, 0, 32'h0,   0, 0, 0, 32'hF0,       0, 32'h100));
        tbl.push_back(mkv(0, 12'h300, 32'h0,        1, 1, 0, 1, 32'h0,   1, 0, 0, 32'h1880,     0, 32'h100));
        tbl.push_back(mkv(0, 12'h300, 32'h0,        1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h1888,     0, 32'h100));
        tbl.push_back(mkv(0, 12'h344, 32'h0,        1, 0, 0, 1, 32'h200, 0, 0, 0, 32'h0,        0, 32'h100));
        tbl.push_back(mkv(1, 12'h300, 32'h0,        1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h1888,     0, 32'h100));
        tbl.push_back(mkv(0, 12'h300, 32'h0,        1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h1800,     0, 32'h0));
        tbl.push_back(mkv(0, 12'h305, 32'h0,        1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,        0, 32'h0));

        foreach (tbl[i]) begin
            drv(tbl[i]);
            #1;
            chk($sformatf("row%0d rdata", i), bus0.rdata, tbl[i].xr);
            chk($sformatf("row%0d excep", i), {31'd0, bus0.excep},
                {31'd0, tbl[i].xe});
            chk($sformatf("row%0d epc", i), bus0.epc, tbl[i].xp);
            @(negedge clk);
        end

        // Coincident interrupts: vectored vs direct mtvec.
        drv(z);
        @(negedge clk);
        drv(mkv(0, 12'h305, 32'h1001, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drv(mkv(0, 12'h304, 32'h880, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        @(negedge clk);
        drv(mkv(0, 12'h300, 32'h8, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        @(negedge clk);
        drv(mkv(0, 12'h305, 32'h0, 1, 0, 0, 1, 32'h300, 0, 1, 1, 0, 0, 0));
        #1;
        chk("vec mtvec1", bus1.rdata, 32'h1001);
        chk("vec mtvec0", bus0.rdata, 32'h1000);
        chk("vec excep1", {31'd0, bus1.excep}, 32'h1);
        chk("vec epc1", bus1.epc, 32'h102C);
        chk("vec epc0", bus0.epc, 32'h1000);
        @(negedge clk);
        drv(mkv(0, 12'h342, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("vec mcause1", bus1.rdata, 32'h8000_000B);
        chk("vec mepc1", bus1.epc, 32'h300);
        @(negedge clk);

`ifdef CSR_COUNTERS_EN
        drv(mkv(0, 12'h300, 32'h8, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        @(negedge clk);
        drv(mkv(0, 12'hB02, 32'h5, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        @(negedge clk);
        drv(mkv(0, 12'hB02, 32'h0, 1, 0, 0, 1, 32'h400, 0, 1, 1, 0, 0, 0));
        #1;
        chk("cnt trap excep", {31'd0, bus0.excep}, 32'h1);
        chk("cnt instret0", bus0.rdata, 32'h5);
        @(negedge clk);
        drv(mkv(0, 12'hB02, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("cnt instret1", bus0.rdata, 32'h5);
        @(negedge clk);
        drv(mkv(0, 12'hB00, 32'hFFFF_FFFE, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drv(mkv(0, 12'hB80, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("cnt cycleh0", bus0.rdata, 32'h0);
        drv(mkv(0, 12'hB00, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("cnt cyc fe", bus0.rdata, 32'hFFFF_FFFE);
        @(negedge clk);
        #1;
        chk("cnt cyc ff", bus0.rdata, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        chk("cnt cyc wrap", bus0.rdata, 32'h0);
        drv(mkv(0, 12'hB80, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("cnt cycleh1", bus0.rdata, 32'h1);
        @(negedge clk);
`else
        drv(mkv(0, 12'hB00, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("nocnt mcycle", bus0.rdata, 32'h0);
        @(negedge clk);
`endif

        // Randomized run against the model, both builds.
        drv(z);
        @(negedge clk);
        mreset(0);
        mreset(1);
        ie_r = 1'b0;
        it_r = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) ie_r = ~ie_r;
            if ($urandom_range(0, 7) == 0) it_r = ~it_r;
            rst            = ($urandom_range(0, 299) == 0);
            bus0.addr      = alist[$urandom_range(0, 13)];
            bus0.wdata     = ($urandom_range(0, 1) == 0)
                           ? $urandom : 32'($urandom_range(0, 15)) << 3;
            bus0.csr_rd    = 1'($urandom_range(0, 1));
            bus0.csr_wr    = 1'($urandom_range(0, 1));
            bus0.csr_op    = 2'($urandom_range(0, 3));
            bus0.valid     = 1'($urandom_range(0, 1));
            bus0.pc        = $urandom;
            bus0.is_mret   = ($urandom_range(0, 3) == 0);
            bus0.irq_ext   = ie_r;
            bus0.irq_timer = it_r;
            #1;
            mstep(0, bus0.rdata, bus0.excep, bus0.epc);
            mstep(1, bus1.rdata, bus1.excep, bus1.epc);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
